lcd_init_sequencer: RTL
=======================

Name: lcd_init_sequencer

Overview:
Controller that sits between user logic and the 4-bit LCD nibble sender (byte-in, E-strobe, 40 us post-write delay).
- After reset, autonomously runs the HD44780 4-bit power-on init sequence.
- Then arbitrates single-byte command/data writes from user logic onto the sender via a valid/ready handshake.
- Drives RS/RW and inserts the long execution waits that the sender does not cover: power-on and clear/home.

Parameters:
POWERON_WAIT, 750000, cycles to wait after reset before the first write (15 ms at 50 MHz).
LONG_CMD_WAIT, 82000, extra cycles after clear/home commands (1.64 ms at 50 MHz).
DONE_TIMEOUT, 200000, max cycles to wait for sender done before flagging an error.

Ports:
Clock  in  1  system clock.
Reset  in  1  asynchronous, active-low reset.
iReq  in  1  user write request (valid).
iRS  in  1  user register select: 0 = command, 1 = data.
iData  in  8  user byte.
oReady  out  1  high only in IDLE; transfer occurs when iReq && oReady at a rising edge.
oInitDone  out  1  high once the init sequence has completed; stays high until reset.
oError  out  1  sticky; set on sender timeout, cleared only by reset.
oLCD_RS  out  1  RS to the LCD, registered.
oLCD_RW  out  1  constant 0 (write only).
oSenderBegin  out  1  one-cycle pulse that starts a sender write.
oSenderData  out  8  byte to the sender; held stable from the pulse until done.
iSenderDone  in  1  one-cycle done pulse from the sender.

Behaviour:
- Reset (Reset == 0, asynchronous):
  - State = PWR_WAIT, counter = 0, init index = 0.
  - oReady = 0, oInitDone = 0, oError = 0, oLCD_RS = 0, oLCD_RW = 0, oSenderBegin = 0, oSenderData = 8'h00.
  - Reset mid-operation aborts everything and reruns the full init sequence.
  - The sender's own reset is tied to ~Reset at the top level.
- Init ROM, indices 0..5: 8'h33, 8'h32, 8'h28, 8'h06, 8'h0C, 8'h01. All entries use RS = 0.
- States:
  - PWR_WAIT: count to POWERON_WAIT-1, then go to INIT_ISSUE.
  - INIT_ISSUE: load oSenderData = ROM[idx], RS = 0; pulse oSenderBegin for 1 cycle; go to INIT_WAIT.
  - INIT_WAIT: on iSenderDone:
    - if ROM[idx] == 8'h01, go to INIT_LONG;
    - else if idx == 5, go to IDLE;
    - else idx++ and go to INIT_ISSUE.
  - INIT_LONG: count LONG_CMD_WAIT cycles; then if idx == 5 set oInitDone and go to IDLE, else idx++ and go to INIT_ISSUE.
  - IDLE: oReady = 1. On iReq, capture iRS/iData into oLCD_RS/oSenderData, drop oReady next cycle, go to WR_ISSUE.
  - WR_ISSUE: pulse oSenderBegin for 1 cycle; go to WR_WAIT.
  - WR_WAIT: on iSenderDone:
    - if RS == 0 and byte is in {8'h01, 8'h02, 8'h03}, go to WR_LONG;
    - else go to IDLE.
  - WR_LONG: count LONG_CMD_WAIT cycles, then go to IDLE.
- Timeout: in INIT_WAIT or WR_WAIT, if DONE_TIMEOUT cycles elapse with no iSenderDone, set oError and go to IDLE. Init is abandoned and oInitDone stays 0.
- Requests and oInitDone:
  - iReq is ignored while oReady = 0; no queuing.
  - Requesters must hold iReq until accepted.
  - After a timeout, user writes are still accepted with oInitDone = 0.
- oSenderData and oLCD_RS are stable from WR_ISSUE/INIT_ISSUE until the state is left after iSenderDone.
- Counters are 32-bit unsigned, cleared on every state change; no wrap within legal parameter ranges.
- An iSenderDone arriving in any state other than *_WAIT is ignored.
- Latency from accept to oSenderBegin: 1 cycle (accept edge, then pulse in the following cycle).

Decomposition:
- Package lcd_pkg holds:
  - state encodings, 4-bit;
  - init ROM constants and INIT_LEN = 6;
  - LCD command constants: CMD_CLEAR = 8'h01, CMD_HOME = 8'h02, CMD_FUNC_4BIT_2L = 8'h28, CMD_ENTRY_INC = 8'h06, CMD_DISP_ON = 8'h0C.
- One natural sub-module: lcd_delay_counter (load, count, terminal-count flag), shared by the PWR, LONG and timeout waits.

Test Plan:
- Reset release, with POWERON_WAIT = 100, LONG_CMD_WAIT = 50, sender model done after 20 cycles:
  - oSenderBegin pulses with data 33, 32, 28, 06, 0C, 01 in order, RS = 0;
  - first pulse is at cycle 101;
  - a ≥50-cycle gap follows the 8'h01 done;
  - then oInitDone = 1 and oReady = 1.
- After init, iReq with RS = 1, data 8'h41 -> one pulse with oSenderData = 41, oLCD_RS = 1; oReady is back to 1 exactly 1 cycle after done.
- User command 8'h01 with RS = 0 -> oReady stays 0 for LONG_CMD_WAIT cycles after done.
- User data 8'h01 with RS = 1 -> no long wait; oReady returns 1 cycle after done.
- Sender model never asserts done, with DONE_TIMEOUT = 30 -> oError = 1 after 30 cycles in INIT_WAIT; state goes to IDLE with oInitDone = 0.
- Reset asserted mid-WR_WAIT -> all outputs take their reset values immediately (asynchronously); after release, the init sequence restarts from 8'h33.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state encodings, init ROM and LCD command constants
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_PWR_WAIT   = 4'd0,
        ST_INIT_ISSUE = 4'd1,
        ST_INIT_WAIT  = 4'd2,
        ST_INIT_LONG  = 4'd3,
        ST_IDLE       = 4'd4,
        ST_WR_ISSUE   = 4'd5,
        ST_WR_WAIT    = 4'd6,
        ST_WR_LONG    = 4'd7
    } state_e;

    localparam int INIT_LEN = 6;

    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT     = 8'h03;
    localparam logic [7:0] CMD_FUNC_4BIT_2L = 8'h28;
    localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
    localparam logic [7:0] INIT_WAKE_8BIT   = 8'h33;
    localparam logic [7:0] INIT_SET_4BIT    = 8'h32;

    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return INIT_WAKE_8BIT;
            3'd1:    return INIT_SET_4BIT;
            3'd2:    return CMD_FUNC_4BIT_2L;
            3'd3:    return CMD_ENTRY_INC;
            3'd4:    return CMD_DISP_ON;
            default: return CMD_CLEAR;
        endcase
    endfunction

    // Clear and both home encodings need the long execution wait.
    function automatic logic is_long_cmd(input logic [7:0] b);
        return (b == CMD_CLEAR) || (b == CMD_HOME) || (b == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// rtl/lcd_delay_counter.sv - 32-bit up counter with clear and terminal-count flag
module lcd_delay_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] limit,
    output logic        tc
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == limit);

endmodule

// File: rtl/lcd_init_sequencer.sv
// rtl/lcd_init_sequencer.sv - HD44780 4-bit init sequencer and user write arbiter
module lcd_init_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned POWERON_WAIT  = 750000,
    parameter int unsigned LONG_CMD_WAIT = 82000,
    parameter int unsigned DONE_TIMEOUT  = 200000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iReq,
    input  logic       iRS,
    input  logic [7:0] iData,
    output logic       oReady,
    output logic       oInitDone,
    output logic       oError,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oSenderBegin,
    output logic [7:0] oSenderData,
    input  logic       iSenderDone
);

    localparam logic [31:0] PWR_LIMIT  = 32'(POWERON_WAIT - 1);
    localparam logic [31:0] LONG_LIMIT = 32'(LONG_CMD_WAIT - 1);
    localparam logic [31:0] TO_LIMIT   = 32'(DONE_TIMEOUT - 1);
    localparam logic [2:0]  INIT_LAST  = 3'(INIT_LEN - 1);

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        ready_q, ready_d;
    logic        init_done_q, init_done_d;
    logic        error_q, error_d;
    logic        rs_q, rs_d;
    logic        begin_q, begin_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] limit;
    logic        cnt_en;
    logic        cnt_tc;

    // One counter serves every wait; it restarts whenever the state changes.
    lcd_delay_counter u_delay (
        .clk   (Clock),
        .rst_n (Reset),
        .clr   (state_d != state_q),
        .en    (cnt_en),
        .limit (limit),
        .tc    (cnt_tc)
    );

    always_comb begin
        cnt_en = 1'b0;
        limit  = TO_LIMIT;
        case (state_q)
            ST_PWR_WAIT:             begin cnt_en = 1'b1; limit = PWR_LIMIT;  end
            ST_INIT_LONG, ST_WR_LONG: begin cnt_en = 1'b1; limit = LONG_LIMIT; end
            ST_INIT_WAIT, ST_WR_WAIT: begin cnt_en = 1'b1; limit = TO_LIMIT;   end
            default:                 begin cnt_en = 1'b0; limit = TO_LIMIT;   end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        error_d     = error_q;
        rs_d        = rs_q;
        begin_d     = 1'b0;
        data_d      = data_q;
        case (state_q)
            ST_PWR_WAIT: begin
                if (cnt_tc) state_d = ST_INIT_ISSUE;
            end
            ST_INIT_ISSUE: begin
                data_d  = init_rom(idx_q);
                rs_d    = 1'b0;
                begin_d = 1'b1;
                state_d = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (iSenderDone) begin
                    if (init_rom(idx_q) == CMD_CLEAR) begin
                        state_d = ST_INIT_LONG;
                    end else if (idx_q == INIT_LAST) begin
                        state_d     = ST_IDLE;
                        ready_d     = 1'b1;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_INIT_ISSUE;
                    end
                end else if (cnt_tc) begin
                    error_d = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_INIT_LONG: begin
                if (cnt_tc) begin
                    if (idx_q == INIT_LAST) begin
                        state_d     = ST_IDLE;
                        ready_d     = 1'b1;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_INIT_ISSUE;
                    end
                end
            end
            ST_IDLE: begin
                if (iReq) begin
                    rs_d    = iRS;
                    data_d  = iData;
                    ready_d = 1'b0;
                    state_d = ST_WR_ISSUE;
                end
            end
            ST_WR_ISSUE: begin
                begin_d = 1'b1;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (iSenderDone) begin
                    if (!rs_q && is_long_cmd(data_q)) begin
                        state_d = ST_WR_LONG;
                    end else begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end
                end else if (cnt_tc) begin
                    error_d = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_LONG: begin
                if (cnt_tc) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_PWR_WAIT;
            idx_q       <= 3'd0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            error_q     <= 1'b0;
            rs_q        <= 1'b0;
            begin_q     <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            error_q     <= error_d;
            rs_q        <= rs_d;
            begin_q     <= begin_d;
            data_q      <= data_d;
        end
    end

    assign oReady       = ready_q;
    assign oInitDone    = init_done_q;
    assign oError       = error_q;
    assign oLCD_RS      = rs_q;
    assign oLCD_RW      = 1'b0;
    assign oSenderBegin = begin_q;
    assign oSenderData  = data_q;

endmodule
